mm_read_arbiter: RTL
====================

MM_READ_ARBITER -- requirements
Module: mm_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of requesting read channels, range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 19: main-memory word address width.
REQ-003 SHALL have parameter DATA_W, default 8: read data width.
REQ-004 SHALL have parameter MEM_LAT, default 1: cycles from mem_raddr registered to mem_rdata valid, range 1..4.
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port req, input, NUM_CH: per-channel read request, level.
REQ-008 SHALL have port addr, input, NUM_CH*ADDR_W: channel i address in bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port gnt, output, NUM_CH: one-hot registered grant, one-cycle pulse.
REQ-010 SHALL have port mem_raddr, output, ADDR_W: registered address to the synchronous RAM read port.
REQ-011 SHALL have port mem_rdata, input, DATA_W: RAM read data.
REQ-012 SHALL have port rdata, output, DATA_W: returned read data, shared by all channels.
REQ-013 SHALL have port rvalid, output, NUM_CH: one-hot, marks the channel owning rdata this cycle.

Function
REQ-014 SHALL evaluate req every cycle and grant at most one channel per cycle; with no req bit set, gnt and mem_raddr SHALL hold (gnt=0, mem_raddr unchanged).
REQ-015 SHALL, on the edge where channel i wins, set gnt[i]=1 and mem_raddr=addr of channel i in the same edge; gnt SHALL be 0 on the following edge unless channel i wins again.
REQ-016 Default arbitration SHALL be fixed priority, highest index highest (channel NUM_CH-1 = test, NUM_CH-2 = VGA, 0 = CPU).
REQ-017 SHALL keep a tag pipeline of MEM_LAT+1 stages carrying the one-hot grant; rvalid SHALL equal the last stage, exactly MEM_LAT+1 cycles after gnt.
REQ-018 SHALL register rdata from mem_rdata on the edge the tag reaches the last stage; rdata SHALL hold its value while rvalid=0.
REQ-019 SHALL accept one new grant per cycle while earlier reads are in flight; back-to-back grants SHALL yield back-to-back rvalid in grant order.
REQ-020 A requester SHALL keep req and addr stable until it sees gnt; dropping req before gnt SHALL cancel the request with no rvalid.
REQ-021 A requester holding req after gnt SHALL be treated as a new request for the next cycle.
REQ-022 Simultaneous requests SHALL grant exactly one; losers SHALL stay pending with no data lost.

Reset
REQ-023 Asserting rst SHALL immediately clear gnt, rvalid, the tag pipeline, mem_raddr and rdata to 0 and the round-robin pointer to 0.
REQ-024 Reads in flight at reset SHALL be discarded: no rvalid for them after rst deasserts.
REQ-025 The first grant SHALL occur on the first rising edge after rst deasserts with req nonzero.

Configuration
REQ-026 Macro MM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-027 Without MM_ARB_ROUND_ROBIN_EN: fixed priority per REQ-016; a continuously requesting high channel MAY starve lower ones.
REQ-028 With MM_ARB_ROUND_ROBIN_EN: a pointer p (reset 0) names the highest-priority channel; search order p, p+1, ... mod NUM_CH; after granting i, p SHALL become (i+1) mod NUM_CH; with no grant p SHALL hold.
REQ-029 With MM_ARB_ROUND_ROBIN_EN, any continuously asserted req SHALL be granted within NUM_CH cycles.

Verification
REQ-030 Defaults, MEM_LAT=1: req=001, addr0=0x00123 -> gnt=001 next edge, mem_raddr=0x00123, rvalid=001 two cycles later with rdata=RAM[0x00123].
REQ-031 Fixed priority: req=111 held 3 cycles -> gnt=100 each cycle, channels 0/1 never granted; drop req[2] -> gnt=010 next cycle.
REQ-032 Round-robin build: req=111 held 6 cycles -> gnt sequence 001,010,100,001,010,100.
REQ-033 Pipelining, MEM_LAT=3: grants to ch0 then ch1 on consecutive cycles -> rvalid=001 then 010 on consecutive cycles, 4 cycles after each gnt, correct data each.
REQ-034 Reset mid-read: assert rst one cycle after gnt=010 -> rvalid, gnt, rdata all 0 immediately; no rvalid after release until a new grant.
REQ-035 Cancel: req[1] pulsed for one cycle while req[2] wins -> no gnt[1] and no rvalid[1] ever.

Source files
------------

// File: rtl/mm_read_arbiter.sv
// Main-memory read arbiter: grants one of NUM_CH read channels per cycle, drives the
// synchronous RAM read address, and returns the RAM data tagged with the owning
// channel MEM_LAT+1 cycles after the grant.
// Build option: define MM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default
// is fixed priority with the highest channel index winning.
module mm_read_arbiter #(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    output logic [NUM_CH-1:0]        gnt,
    output logic [ADDR_W-1:0]        mem_raddr,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [NUM_CH-1:0]        rvalid
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              win_valid;
    logic [IDX_W-1:0]  win_idx;
    logic [NUM_CH-1:0] gnt_d, gnt_q;
    logic [ADDR_W-1:0] mem_raddr_d, mem_raddr_q;
    logic [DATA_W-1:0] rdata_q;

    // Tag stage k holds the grant issued k+1 edges earlier; the last stage is rvalid.
    logic [NUM_CH-1:0] tag_q [MEM_LAT+1];

`ifdef MM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_d, ptr_q;
    logic [IDX_W-1:0] cand;

    // Round-robin winner: first requester at or after the pointer, wrapping.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % NUM_CH);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Pointer moves just past the winner; it holds when nobody is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (win_valid) begin
            ptr_d = (win_idx == IDX_W'(NUM_CH - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority winner: the highest set request index overrides lower ones.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (req[i]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end
`endif

    // Grant pulse and RAM address for the winner; address holds when idle.
    always_comb begin
        gnt_d       = '0;
        mem_raddr_d = mem_raddr_q;
        if (win_valid) begin
            gnt_d       = NUM_CH'(1) << win_idx;
            mem_raddr_d = addr[32'(win_idx) * ADDR_W +: ADDR_W];
        end
    end

    // Grant and address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q       <= '0;
            mem_raddr_q <= '0;
        end else begin
            gnt_q       <= gnt_d;
            mem_raddr_q <= mem_raddr_d;
        end
    end

    // Tag pipeline follows the RAM latency; reset discards every read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k <= MEM_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= gnt_q;
            for (int unsigned k = 1; k <= MEM_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Capture RAM data on the edge a tag enters the last stage; hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (|tag_q[MEM_LAT-1]) begin
            rdata_q <= mem_rdata;
        end
    end

    assign gnt       = gnt_q;
    assign mem_raddr = mem_raddr_q;
    assign rdata     = rdata_q;
    assign rvalid    = tag_q[MEM_LAT];

endmodule
